// File: rtl/data_unpack_stream.sv
// data_unpack_stream: width-down converter that splits sop/eop framed IN_W-bit
// words into OUT_W-bit symbols, MSB-first, with downstream backpressure,
// optional zero-padding of the packet-end residual and a framing-error pulse.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   valid_in, ready_out        input word handshake
//   data_in, sop_in, eop_in    input word and its framing
//   valid_out, ready_in        output symbol handshake
//   data_out, sop_out, eop_out output symbol and its framing
//   err_out                    one-cycle pulse after a framing error
module data_unpack_stream #(
   parameter int unsigned IN_W     = 32,
   parameter int unsigned OUT_W    = 7,
   parameter int unsigned PAD_LAST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [IN_W-1:0]  data_in,
   input  logic             sop_in,
   input  logic             eop_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [OUT_W-1:0] data_out,
   output logic             sop_out,
   output logic             eop_out,
   output logic             err_out
);

   localparam int unsigned BUF_W = IN_W + OUT_W;
   localparam int unsigned CNT_W = $clog2(BUF_W + 1);
   localparam bit          PAD   = (PAD_LAST != 0);

   // MSB-aligned bit buffer; bits at and below position BUF_W-1-cnt are always zero
   logic [BUF_W-1:0] bits_q, bits_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             open_q, open_n;
   logic             eop_held_q, eop_held_n;
   logic             sop_pend_q, sop_pend_n;
   logic             err_q, err_n;
   logic             in_xfer, out_xfer;

   // Handshake and symbol outputs are pure functions of registered state
   assign ready_out = rst_n & ~eop_held_q & (cnt_q <= CNT_W'(OUT_W));
   assign valid_out = (cnt_q >= CNT_W'(OUT_W)) | (eop_held_q & PAD & (cnt_q != '0));
   assign data_out  = bits_q[BUF_W-1 -: OUT_W];
   assign sop_out   = sop_pend_q;
   assign eop_out   = eop_held_q & (PAD ? (cnt_q <= CNT_W'(OUT_W))
                                        : (cnt_q <  CNT_W'(2 * OUT_W)));
   assign err_out   = err_q;

   assign in_xfer  = valid_in & ready_out;
   assign out_xfer = valid_out & ready_in;

   // Next state: remove the emitted symbol first, then append the accepted word
   always_comb begin
      bits_n     = bits_q;
      cnt_n      = cnt_q;
      open_n     = open_q;
      eop_held_n = eop_held_q;
      sop_pend_n = sop_pend_q;
      err_n      = 1'b0;

      if (out_xfer) begin
         sop_pend_n = 1'b0;
         if (eop_out) begin
            // final symbol of the packet: any residual is discarded here
            bits_n     = '0;
            cnt_n      = '0;
            eop_held_n = 1'b0;
            open_n     = 1'b0;
         end else begin
            bits_n = bits_q << OUT_W;
            cnt_n  = (cnt_q >= CNT_W'(OUT_W)) ? cnt_q - CNT_W'(OUT_W) : '0;
         end
      end

      if (in_xfer) begin
         if (!open_q && !sop_in) begin
            // continuation word with no open packet: dropped
            err_n = 1'b1;
         end else begin
            if (open_q && sop_in) err_n = 1'b1;
            if (!open_q) begin
               open_n     = 1'b1;
               sop_pend_n = 1'b1;
            end
            // ready_out guarantees cnt_n <= OUT_W, so the word always fits
            bits_n = bits_n | (BUF_W'(data_in) << (CNT_W'(BUF_W - IN_W) - cnt_n));
            cnt_n  = cnt_n + CNT_W'(IN_W);
            if (eop_in) eop_held_n = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q     <= '0;
         cnt_q      <= '0;
         open_q     <= 1'b0;
         eop_held_q <= 1'b0;
         sop_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         bits_q     <= bits_n;
         cnt_q      <= cnt_n;
         open_q     <= open_n;
         eop_held_q <= eop_held_n;
         sop_pend_q <= sop_pend_n;
         err_q      <= err_n;
      end
   end

endmodule

// File: tb/tb_data_unpack_stream.sv
// Directed bench for data_unpack_stream (32->7). One instance pads the last
// symbol, a second discards the residual. Each instance has a scoreboard of
// hand-computed {sop,eop,data} symbols checked on every output transfer.
module tb_data_unpack_stream;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        valid_in, sop_in, eop_in, ready_in;
   logic [31:0] data_in;
   logic        ready_out, valid_out, sop_out, eop_out, err_out;
   logic [6:0]  data_out;

   logic        p0_valid_in, p0_sop_in, p0_eop_in, p0_ready_in;
   logic [31:0] p0_data_in;
   logic        p0_ready_out, p0_valid_out, p0_sop_out, p0_eop_out, p0_err_out;
   logic [6:0]  p0_data_out;

   logic [8:0]  exp_q[$];
   logic [8:0]  p0_q[$];
   logic [8:0]  mon_e, p0_mon_e;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   data_unpack_stream #(.IN_W(32), .OUT_W(7), .PAD_LAST(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
      .sop_in(sop_in), .eop_in(eop_in),
      .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
      .sop_out(sop_out), .eop_out(eop_out), .err_out(err_out)
   );

   data_unpack_stream #(.IN_W(32), .OUT_W(7), .PAD_LAST(0)) u_dut_p0 (
      .clk(clk), .rst_n(rst_n),
      .valid_in(p0_valid_in), .ready_out(p0_ready_out), .data_in(p0_data_in),
      .sop_in(p0_sop_in), .eop_in(p0_eop_in),
      .valid_out(p0_valid_out), .ready_in(p0_ready_in), .data_out(p0_data_out),
      .sop_out(p0_sop_out), .eop_out(p0_eop_out), .err_out(p0_err_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input bit p0, input logic s, input logic e, input logic [6:0] d);
      if (p0) p0_q.push_back({s, e, d});
      else    exp_q.push_back({s, e, d});
   endtask

   // Scoreboards: a transfer seen at the negedge completes at the next posedge
   always @(negedge clk) begin
      if (rst_n && valid_out && ready_in) begin
         if (exp_q.size() == 0) check("sym pending", 32'(exp_q.size()), 32'd1);
         else begin
            mon_e = exp_q.pop_front();
            check("sym", 32'({sop_out, eop_out, data_out}), 32'(mon_e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && p0_valid_out && p0_ready_in) begin
         if (p0_q.size() == 0) check("p0 sym pending", 32'(p0_q.size()), 32'd1);
         else begin
            p0_mon_e = p0_q.pop_front();
            check("p0 sym", 32'({p0_sop_out, p0_eop_out, p0_data_out}), 32'(p0_mon_e));
         end
      end
   end

   // Present a word until accepted; returns #1 after the accepting edge
   task automatic drive_word(input bit p0, input logic [31:0] d, input logic s, input logic e);
      int t;
      t = 0;
      if (p0) begin p0_valid_in = 1'b1; p0_data_in = d; p0_sop_in = s; p0_eop_in = e; end
      else    begin valid_in    = 1'b1; data_in    = d; sop_in    = s; eop_in    = e; end
      @(negedge clk);
      while (!(p0 ? p0_ready_out : ready_out) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("accept timeout", 32'(p0 ? p0_ready_out : ready_out), 32'd1);
      @(posedge clk);
      #1;
      if (p0) p0_valid_in = 1'b0;
      else    valid_in    = 1'b0;
   endtask

   task automatic wait_drain(input bit p0);
      int t;
      t = 0;
      while ((p0 ? p0_q.size() : exp_q.size()) != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", 32'(p0 ? p0_q.size() : exp_q.size()), 32'd0);
      check("idle valid", 32'(p0 ? p0_valid_out : valid_out), 32'd0);
   endtask

   logic [3:0] pat;

   initial begin
      rst_n = 1'b0;
      valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; data_in = '0; ready_in = 1'b1;
      p0_valid_in = 1'b0; p0_sop_in = 1'b0; p0_eop_in = 1'b0; p0_data_in = '0; p0_ready_in = 1'b1;
      pat = 4'b1001;

      // reset state
      #12;
      check("rst ready", 32'(ready_out), 32'd0);
      check("rst valid", 32'(valid_out), 32'd0);
      check("rst data", 32'(data_out), 32'd0);
      check("rst flags", 32'({sop_out, eop_out, err_out}), 32'd0);
      rst_n = 1'b1;
      #1;
      check("release ready", 32'(ready_out), 32'd1);
      @(posedge clk);
      #1;

      // 1: all-ones single word, padded residual; ready_out low until last symbol
      push(0, 1, 0, 7'h7F); push(0, 0, 0, 7'h7F); push(0, 0, 0, 7'h7F);
      push(0, 0, 0, 7'h7F); push(0, 0, 1, 7'h78);
      drive_word(0, 32'hFFFF_FFFF, 1, 1);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         check("t1 ready low", 32'(ready_out), 32'd0);
         @(posedge clk);
         #1;
      end
      wait_drain(0);
      check("t1 ready after", 32'(ready_out), 32'd1);

      // 2: residual discarded; next packet can start right after eop symbol
      push(1, 1, 0, 7'h7F); push(1, 0, 0, 7'h7F); push(1, 0, 0, 7'h7F); push(1, 0, 1, 7'h7F);
      drive_word(1, 32'hFFFF_FFFF, 1, 1);
      wait_drain(1);
      check("t2 ready after", 32'(p0_ready_out), 32'd1);
      push(1, 1, 0, 7'h52); push(1, 0, 0, 7'h69); push(1, 0, 0, 7'h34); push(1, 0, 1, 7'h5A);
      drive_word(1, 32'hA5A5_A5A5, 1, 1);
      wait_drain(1);

      // 3: two-word packet
      push(0, 1, 0, 7'h40); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h08); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h01); push(0, 0, 1, 7'h40);
      drive_word(0, 32'h8000_0001, 1, 0);
      drive_word(0, 32'h0000_0003, 0, 1);
      wait_drain(0);

      // 4: downstream stalls; output must hold the pending symbol
      push(0, 1, 0, 7'h09); push(0, 0, 0, 7'h0D); push(0, 0, 0, 7'h0A);
      push(0, 0, 0, 7'h67); push(0, 0, 1, 7'h40);
      drive_word(0, 32'h1234_5678, 1, 1);
      for (int i = 0; i < 24; i++) begin
         ready_in = pat[i % 4];
         @(negedge clk);
         if (!ready_in && exp_q.size() > 0) begin
            check("stall valid", 32'(valid_out), 32'd1);
            check("stall data", 32'(data_out), 32'(exp_q[0][6:0]));
            check("stall sop/eop", 32'({sop_out, eop_out}), 32'(exp_q[0][8:7]));
         end
         @(posedge clk);
         #1;
      end
      ready_in = 1'b1;
      wait_drain(0);

      // 5: framing errors
      drive_word(0, 32'hDEAD_BEEF, 0, 0);
      check("t5 err orphan", 32'(err_out), 32'd1);
      check("t5 dropped", 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
      check("t5 err pulse", 32'(err_out), 32'd0);
      check("t5 still idle", 32'(valid_out), 32'd0);
      push(0, 1, 0, 7'h7F); push(0, 0, 0, 7'h7F); push(0, 0, 0, 7'h7F); push(0, 0, 0, 7'h7F);
      push(0, 0, 0, 7'h78); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h00); push(0, 0, 1, 7'h00);
      drive_word(0, 32'hFFFF_FFFF, 1, 0);
      check("t5 no err", 32'(err_out), 32'd0);
      drive_word(0, 32'h0000_0000, 1, 1);
      check("t5 err sop", 32'(err_out), 32'd1);
      wait_drain(0);

      // 6: reset mid-packet after symbol 2 of the two-word packet
      push(0, 1, 0, 7'h40); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h08); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h01); push(0, 0, 1, 7'h40);
      drive_word(0, 32'h8000_0001, 1, 0);
      for (int i = 0; i < 50 && exp_q.size() > 8; i++) begin
         @(posedge clk);
         #1;
      end
      check("t6 two symbols", 32'(exp_q.size()), 32'd8);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t6 rst ready", 32'(ready_out), 32'd0);
      check("t6 rst valid", 32'(valid_out), 32'd0);
      check("t6 rst data", 32'(data_out), 32'd0);
      check("t6 rst flags", 32'({sop_out, eop_out, err_out}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("t6 release ready", 32'(ready_out), 32'd1);
      check("t6 release valid", 32'(valid_out), 32'd0);
      push(0, 1, 0, 7'h40); push(0, 0, 0, 7'h00); push(0, 0, 0, 7'h00);
      push(0, 0, 0, 7'h00); push(0, 0, 1, 7'h00);
      drive_word(0, 32'h8000_0000, 1, 1);
      wait_drain(0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
